top_decode: RTL and testbench
=============================

// Module: top_decode
// PURPOSE
//  uDLX ID stage, directly downstream of the fetch stage. Takes the IF/ID
//  instruction and PC, decodes DLX R/I/J formats and reads a 32-entry register
//  file (WB write port). Resolves branches/jumps in ID, sending
//  select_new_pc/new_pc back to fetch, and squashes the wrong-path instruction.
//  Detects load-use and branch-operand hazards and registers the ID/EX bundle.
// PARAMETERS
//  PC_DATA_WIDTH    20  PC / instruction address width
//  INST_DATA_WIDTH  32  instruction width
//  DATA_WIDTH       32  register / datapath width
// PORTS
//  clk                  in   1    CPU core clock
//  rst_n                in   1    CPU core reset, asynchronous, active low
//  instruction_in       in   32   IF/ID instruction (fetch instruction_reg_out)
//  pc_in                in   PC   IF/ID PC of that instruction (fetch new_pc_out)
//  wb_we_in             in   1    WB register write enable
//  wb_addr_in           in   5    WB destination register
//  wb_data_in           in   DW   WB write data
//  ex_rd_in             in   5    rd of instruction now in EX
//  ex_reg_write_in      in   1    EX instruction writes rd
//  ex_mem_read_in       in   1    EX instruction is a load
//  mem_rd_in            in   5    rd of instruction now in MEM
//  mem_reg_write_in     in   1    MEM instruction writes rd
//  select_new_pc_out    out  1    comb: redirect fetch this cycle
//  new_pc_out           out  PC   comb: redirect target
//  stall_out            out  1    comb: fetch must hold pc and IF/ID register
//  id_ex_rs1_data_out   out  DW   registered rs1 value
//  id_ex_rs2_data_out   out  DW   registered rs2 value
//  id_ex_imm_out        out  DW   registered sign-extended imm16
//  id_ex_rs1_addr_out / id_ex_rs2_addr_out  out 5  registered source indices
//  id_ex_rd_out         out  5    registered destination
//  id_ex_opcode_out     out  6    registered opcode; id_ex_func_out out 11 func
//  id_ex_reg_write_out / id_ex_mem_read_out / id_ex_mem_write_out  out 1
//  id_ex_pc4_out        out  PC   registered pc_in+4 (link value)
// BEHAVIOUR
//  Fields: op=[31:26] rs1=[25:21] rs2/rdI=[20:16] rdR=[15:11] func=[10:0]
//   imm16=[15:0] off26=[25:0]. Opcodes: R=00 J=02 JAL=03 BEQZ=04 BNEZ=05
//   JR=12 JALR=13 LW=23 SW=2B; any other = ALU-immediate.
//  rd: R->rdR; LW/ALU-imm->rdI; JAL/JALR->31. reg_write: R, LW, ALU-imm,
//   JAL, JALR; forced 0 whenever rd==0. mem_read=LW, mem_write=SW.
//  Sources used: rs1 by all except J/JAL; rs2 only by R and SW.
//  Regfile: 32xDW, r0 always reads 0 and ignores writes; write on posedge;
//   same-cycle WB write to a read index is bypassed (write-through).
//  Effective instruction = 0 (NOP) when flush_q=1, else instruction_in.
//  Redirect (ID, comb, suppressed when stall_out): BEQZ taken if rs1==0,
//   BNEZ if rs1!=0, target pc_in+4+sext(imm16); J/JAL pc_in+4+sext(off26);
//   JR/JALR rs1[PC-1:0]. All sums modulo 2^PC_DATA_WIDTH.
//  flush_q: set on posedge when select_new_pc_out=1, cleared next cycle;
//   squashes the sequential instruction fetch captured on the same edge.
//  stall_out=1 if (ex_mem_read_in & ex_rd_in!=0 & ex_rd_in matches a used src)
//   or (op in BEQZ/BNEZ/JR/JALR & rs1!=0 & ((ex_reg_write_in & ex_rd_in==rs1)
//   | (mem_reg_write_in & mem_rd_in==rs1))). Never asserted while flush_q=1.
//  On stall: ID/EX loads a bubble (reg_write/mem_read/mem_write=0, rest 0);
//   inputs are held by fetch, so decode repeats next cycle. Latency: 1 cycle.
//  Reset (async): all id_ex_* outputs 0, flush_q 0, all registers 0; comb
//   outputs follow from NOP decode (select_new_pc_out=0, stall_out=0).
//  Reset mid-stall or mid-flush clears both; first post-reset instruction valid.
// TESTING
//  1 WB writes r5=0x1234 while ID reads rs1=r5 -> id_ex_rs1_data_out=0x1234 next edge.
//  2 LW r3 in EX, ID holds ADD r4,r3,r2 -> stall_out=1 one cycle, EX bubble, then ADD issues.
//  3 BEQZ r0,+8 at pc 0x100 -> select_new_pc_out=1, new_pc_out=0x10C; next instr becomes NOP.
//  4 JAL at pc 0x200 -> rd=31, reg_write=1, id_ex_pc4_out=0x204, redirect asserted.
//  5 BNEZ r7 with ADD r7 in EX -> stall, no redirect; next cycle r7 in MEM -> stall again.
//  6 Write r0=0xFFFF, read r0 -> 0; assert rst_n low during flush_q -> all outputs 0.

Source files
------------

// File: rtl/top_decode.sv
// uDLX instruction-decode stage: field decode, 32-entry register file with WB bypass,
// branch/jump resolution, hazard stall generation and the ID/EX pipeline register.
module top_decode #(
  parameter int unsigned PC_DATA_WIDTH   = 20,
  parameter int unsigned INST_DATA_WIDTH = 32,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [INST_DATA_WIDTH-1:0] instruction_in,
  input  logic [PC_DATA_WIDTH-1:0]   pc_in,
  input  logic                       wb_we_in,
  input  logic [4:0]                 wb_addr_in,
  input  logic [DATA_WIDTH-1:0]      wb_data_in,
  input  logic [4:0]                 ex_rd_in,
  input  logic                       ex_reg_write_in,
  input  logic                       ex_mem_read_in,
  input  logic [4:0]                 mem_rd_in,
  input  logic                       mem_reg_write_in,
  output logic                       select_new_pc_out,
  output logic [PC_DATA_WIDTH-1:0]   new_pc_out,
  output logic                       stall_out,
  output logic [DATA_WIDTH-1:0]      id_ex_rs1_data_out,
  output logic [DATA_WIDTH-1:0]      id_ex_rs2_data_out,
  output logic [DATA_WIDTH-1:0]      id_ex_imm_out,
  output logic [4:0]                 id_ex_rs1_addr_out,
  output logic [4:0]                 id_ex_rs2_addr_out,
  output logic [4:0]                 id_ex_rd_out,
  output logic [5:0]                 id_ex_opcode_out,
  output logic [10:0]                id_ex_func_out,
  output logic                       id_ex_reg_write_out,
  output logic                       id_ex_mem_read_out,
  output logic                       id_ex_mem_write_out,
  output logic [PC_DATA_WIDTH-1:0]   id_ex_pc4_out
);

  localparam int unsigned NREG = 32;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQZ = 6'h04;
  localparam logic [5:0] OP_BNEZ = 6'h05;
  localparam logic [5:0] OP_JR   = 6'h12;
  localparam logic [5:0] OP_JALR = 6'h13;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [4:0] LINK_REG = 5'd31;

  logic                       flush_q, flush_d;
  logic [INST_DATA_WIDTH-1:0] inst_c;
  logic [5:0]                 op_c;
  logic [4:0]                 rs1_c, rs2_c, rdr_c;
  logic [10:0]                func_c;
  logic [15:0]                imm16_c;
  logic [25:0]                off26_c;
  logic [DATA_WIDTH-1:0]      regs_q [NREG];
  logic [DATA_WIDTH-1:0]      rs1_data_c, rs2_data_c, imm_c;
  logic [PC_DATA_WIDTH-1:0]   pc4_c, br_off_c, j_off_c, target_c;
  logic [4:0]                 rd_c;
  logic                       reg_write_c, mem_read_c, mem_write_c;
  logic                       uses_rs1_c, uses_rs2_c, reg_branch_c, taken_c;
  logic                       load_use_c, branch_haz_c;

  // Wrong-path instruction after a redirect is replaced by an all-zero NOP.
  assign inst_c  = flush_q ? '0 : instruction_in;
  assign op_c    = inst_c[31:26];
  assign rs1_c   = inst_c[25:21];
  assign rs2_c   = inst_c[20:16];
  assign rdr_c   = inst_c[15:11];
  assign func_c  = inst_c[10:0];
  assign imm16_c = inst_c[15:0];
  assign off26_c = inst_c[25:0];

  assign imm_c    = {{(DATA_WIDTH-16){imm16_c[15]}}, imm16_c};
  assign pc4_c    = pc_in + PC_DATA_WIDTH'(4);
  assign br_off_c = PC_DATA_WIDTH'($signed(imm16_c));
  assign j_off_c  = PC_DATA_WIDTH'($signed(off26_c));

  // Register file; r0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_we_in && wb_addr_in != '0) begin
      regs_q[wb_addr_in] <= wb_data_in;
    end
  end

  assign rs1_data_c = (rs1_c == '0) ? '0 :
                      (wb_we_in && wb_addr_in == rs1_c) ? wb_data_in : regs_q[rs1_c];
  assign rs2_data_c = (rs2_c == '0) ? '0 :
                      (wb_we_in && wb_addr_in == rs2_c) ? wb_data_in : regs_q[rs2_c];

  // Format decode and branch/jump resolution.
  always_comb begin
    rd_c         = '0;
    reg_write_c  = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    uses_rs1_c   = 1'b1;
    uses_rs2_c   = 1'b0;
    reg_branch_c = 1'b0;
    taken_c      = 1'b0;
    target_c     = pc4_c + br_off_c;
    case (op_c)
      OP_R:    begin rd_c = rdr_c; reg_write_c = 1'b1; uses_rs2_c = 1'b1; end
      OP_J:    begin uses_rs1_c = 1'b0; taken_c = 1'b1; target_c = pc4_c + j_off_c; end
      OP_JAL:  begin
        uses_rs1_c = 1'b0; taken_c = 1'b1; target_c = pc4_c + j_off_c;
        rd_c = LINK_REG; reg_write_c = 1'b1;
      end
      OP_BEQZ: begin reg_branch_c = 1'b1; taken_c = (rs1_data_c == '0); end
      OP_BNEZ: begin reg_branch_c = 1'b1; taken_c = (rs1_data_c != '0); end
      OP_JR:   begin
        reg_branch_c = 1'b1; taken_c = 1'b1; target_c = rs1_data_c[PC_DATA_WIDTH-1:0];
      end
      OP_JALR: begin
        reg_branch_c = 1'b1; taken_c = 1'b1; target_c = rs1_data_c[PC_DATA_WIDTH-1:0];
        rd_c = LINK_REG; reg_write_c = 1'b1;
      end
      OP_LW:   begin rd_c = rs2_c; reg_write_c = 1'b1; mem_read_c = 1'b1; end
      OP_SW:   begin uses_rs2_c = 1'b1; mem_write_c = 1'b1; end
      default: begin rd_c = rs2_c; reg_write_c = 1'b1; end
    endcase
    if (rd_c == '0) reg_write_c = 1'b0;
  end

  // Branches compare in ID, so any in-flight producer of rs1 must retire first.
  assign load_use_c   = ex_mem_read_in && ex_rd_in != '0 &&
                        ((uses_rs1_c && ex_rd_in == rs1_c) || (uses_rs2_c && ex_rd_in == rs2_c));
  assign branch_haz_c = reg_branch_c && rs1_c != '0 &&
                        ((ex_reg_write_in && ex_rd_in == rs1_c) ||
                         (mem_reg_write_in && mem_rd_in == rs1_c));

  assign stall_out         = !flush_q && (load_use_c || branch_haz_c);
  assign select_new_pc_out = taken_c && !stall_out;
  assign new_pc_out        = target_c;
  assign flush_d           = select_new_pc_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flush_q <= 1'b0;
    else        flush_q <= flush_d;
  end

  // ID/EX register; a stall inserts an all-zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || stall_out) begin
      id_ex_rs1_data_out  <= '0;
      id_ex_rs2_data_out  <= '0;
      id_ex_imm_out       <= '0;
      id_ex_rs1_addr_out  <= '0;
      id_ex_rs2_addr_out  <= '0;
      id_ex_rd_out        <= '0;
      id_ex_opcode_out    <= '0;
      id_ex_func_out      <= '0;
      id_ex_reg_write_out <= 1'b0;
      id_ex_mem_read_out  <= 1'b0;
      id_ex_mem_write_out <= 1'b0;
      id_ex_pc4_out       <= '0;
    end else begin
      id_ex_rs1_data_out  <= rs1_data_c;
      id_ex_rs2_data_out  <= rs2_data_c;
      id_ex_imm_out       <= imm_c;
      id_ex_rs1_addr_out  <= rs1_c;
      id_ex_rs2_addr_out  <= rs2_c;
      id_ex_rd_out        <= rd_c;
      id_ex_opcode_out    <= op_c;
      id_ex_func_out      <= func_c;
      id_ex_reg_write_out <= reg_write_c;
      id_ex_mem_read_out  <= mem_read_c;
      id_ex_mem_write_out <= mem_write_c;
      id_ex_pc4_out       <= pc4_c;
    end
  end

endmodule

// File: tb/tb_top_decode.sv
// Bench for top_decode: an instruction-level model predicts redirect/stall and the
// ID/EX bundle each cycle; directed literal checks pin the model on key scenarios.
module tb_top_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction_in;
  logic [19:0] pc_in;
  logic        wb_we_in;
  logic [4:0]  wb_addr_in;
  logic [31:0] wb_data_in;
  logic [4:0]  ex_rd_in;
  logic        ex_reg_write_in;
  logic        ex_mem_read_in;
  logic [4:0]  mem_rd_in;
  logic        mem_reg_write_in;
  logic        select_new_pc_out;
  logic [19:0] new_pc_out;
  logic        stall_out;
  logic [31:0] id_ex_rs1_data_out, id_ex_rs2_data_out, id_ex_imm_out;
  logic [4:0]  id_ex_rs1_addr_out, id_ex_rs2_addr_out, id_ex_rd_out;
  logic [5:0]  id_ex_opcode_out;
  logic [10:0] id_ex_func_out;
  logic        id_ex_reg_write_out, id_ex_mem_read_out, id_ex_mem_write_out;
  logic [19:0] id_ex_pc4_out;

  top_decode dut (
    .clk(clk), .rst_n(rst_n), .instruction_in(instruction_in), .pc_in(pc_in),
    .wb_we_in(wb_we_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
    .ex_rd_in(ex_rd_in), .ex_reg_write_in(ex_reg_write_in), .ex_mem_read_in(ex_mem_read_in),
    .mem_rd_in(mem_rd_in), .mem_reg_write_in(mem_reg_write_in),
    .select_new_pc_out(select_new_pc_out), .new_pc_out(new_pc_out), .stall_out(stall_out),
    .id_ex_rs1_data_out(id_ex_rs1_data_out), .id_ex_rs2_data_out(id_ex_rs2_data_out),
    .id_ex_imm_out(id_ex_imm_out), .id_ex_rs1_addr_out(id_ex_rs1_addr_out),
    .id_ex_rs2_addr_out(id_ex_rs2_addr_out), .id_ex_rd_out(id_ex_rd_out),
    .id_ex_opcode_out(id_ex_opcode_out), .id_ex_func_out(id_ex_func_out),
    .id_ex_reg_write_out(id_ex_reg_write_out), .id_ex_mem_read_out(id_ex_mem_read_out),
    .id_ex_mem_write_out(id_ex_mem_write_out), .id_ex_pc4_out(id_ex_pc4_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sel;
    logic [19:0] npc;
    logic        stall;
    logic [31:0] rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rd;
    logic [5:0]  op;
    logic [10:0] fn;
    logic        rw, mr, mw;
    logic [19:0] pc4;
  } exp_t;

  localparam logic [5:0] J = 6'h02, JAL = 6'h03, BEQZ = 6'h04, BNEZ = 6'h05;
  localparam logic [5:0] JR = 6'h12, JALR = 6'h13, LW = 6'h23, SW = 6'h2B, ADDI = 6'h08;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mregs [32];
  logic        flush_m;
  exp_t        cur, exp_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] rf(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_we_in && wb_addr_in == a) return wb_data_in;
    return mregs[a];
  endfunction

  // Instruction-level reference: what ID must do with the current inputs.
  function automatic exp_t model();
    exp_t        e;
    logic [31:0] in;
    logic [5:0]  op;
    logic [4:0]  a1, a2;
    bit          u1, u2, tk;
    int          t;
    e  = '0;
    in = flush_m ? 32'h0 : instruction_in;
    op = in[31:26]; a1 = in[25:21]; a2 = in[20:16];
    e.op = op; e.rs1a = a1; e.rs2a = a2; e.fn = in[10:0];
    e.imm  = {{16{in[15]}}, in[15:0]};
    e.rs1d = rf(a1); e.rs2d = rf(a2);
    e.pc4  = pc_in + 20'd4;
    if (op == 6'h00) e.rd = in[15:11];
    else if (op == JAL || op == JALR) e.rd = 5'd31;
    else if (op inside {J, BEQZ, BNEZ, JR, SW}) e.rd = 5'd0;
    else e.rd = a2;
    e.rw = (e.rd != 5'd0);
    e.mr = (op == LW);
    e.mw = (op == SW);
    u1 = !(op inside {J, JAL});
    u2 = (op == 6'h00) || (op == SW);
    e.stall = (ex_mem_read_in && ex_rd_in != 0 &&
               ((u1 && ex_rd_in == a1) || (u2 && ex_rd_in == a2))) ||
              ((op inside {BEQZ, BNEZ, JR, JALR}) && a1 != 0 &&
               ((ex_reg_write_in && ex_rd_in == a1) || (mem_reg_write_in && mem_rd_in == a1)));
    tk = 1'b0; t = 0;
    case (op)
      BEQZ, BNEZ: begin
        tk = (op == BEQZ) ? (e.rs1d == 0) : (e.rs1d != 0);
        t  = int'(pc_in) + 4 + int'($signed(in[15:0]));
      end
      J, JAL:   begin tk = 1'b1; t = int'(pc_in) + 4 + int'($signed(in[25:0])); end
      JR, JALR: begin tk = 1'b1; t = int'(e.rs1d); end
      default:  ;
    endcase
    e.npc = t[19:0];
    e.sel = tk && !e.stall;
    return e;
  endfunction

  task automatic do_reset();
    exp_q   = '0;
    flush_m = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
  endtask

  // Per-cycle compare against the model, on the falling edge.
  task automatic mid();
    @(negedge clk);
    cur = model();
    chk("stall", 32'(stall_out), 32'(cur.stall));
    chk("select_new_pc", 32'(select_new_pc_out), 32'(cur.sel));
    if (cur.sel) chk("new_pc", 32'(new_pc_out), 32'(cur.npc));
    chk("rs1_data", id_ex_rs1_data_out, exp_q.rs1d);
    chk("rs2_data", id_ex_rs2_data_out, exp_q.rs2d);
    chk("imm", id_ex_imm_out, exp_q.imm);
    chk("rs1_addr", 32'(id_ex_rs1_addr_out), 32'(exp_q.rs1a));
    chk("rs2_addr", 32'(id_ex_rs2_addr_out), 32'(exp_q.rs2a));
    chk("rd", 32'(id_ex_rd_out), 32'(exp_q.rd));
    chk("opcode", 32'(id_ex_opcode_out), 32'(exp_q.op));
    chk("func", 32'(id_ex_func_out), 32'(exp_q.fn));
    chk("reg_write", 32'(id_ex_reg_write_out), 32'(exp_q.rw));
    chk("mem_read", 32'(id_ex_mem_read_out), 32'(exp_q.mr));
    chk("mem_write", 32'(id_ex_mem_write_out), 32'(exp_q.mw));
    chk("pc4", 32'(id_ex_pc4_out), 32'(exp_q.pc4));
  endtask

  task automatic adv();
    @(posedge clk);
    if (!rst_n) do_reset();
    else begin
      exp_q = cur.stall ? '0 : cur;
      if (wb_we_in && wb_addr_in != 0) mregs[wb_addr_in] = wb_data_in;
      flush_m = cur.sel;
    end
    #1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [19:0] pc);
    instruction_in = inst; pc_in = pc;
    mid();
  endtask

  task automatic clr();
    wb_we_in = 0; wb_addr_in = 0; wb_data_in = 0;
    ex_rd_in = 0; ex_reg_write_in = 0; ex_mem_read_in = 0;
    mem_rd_in = 0; mem_reg_write_in = 0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_we_in = 1; wb_addr_in = a; wb_data_in = d;
  endtask

  function automatic logic [31:0] rt(input logic [4:0] s1, s2, d, input logic [10:0] f);
    return {6'h00, s1, s2, d, f};
  endfunction
  function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] s1, d,
                                     input logic [15:0] imm);
    return {op, s1, d, imm};
  endfunction
  function automatic logic [31:0] jt(input logic [5:0] op, input logic [25:0] off);
    return {op, off};
  endfunction

  initial begin
    rst_n = 0; instruction_in = 0; pc_in = 0; clr();
    do_reset();
    issue(32'h0, 20'h0); adv();
    chk("reset_pc4", 32'(id_ex_pc4_out), 32'h0);
    chk("reset_stall", 32'(stall_out), 32'h0);
    rst_n = 1;

    wb(5'd2, 32'h10); issue(32'h0, 20'h0); adv(); clr();
    // WB write-through on rs1
    wb(5'd5, 32'h1234); issue(rt(5, 2, 4, 11'h20), 20'h004); adv(); clr();
    chk("t1_rs1_bypass", id_ex_rs1_data_out, 32'h1234);
    chk("t1_rs2", id_ex_rs2_data_out, 32'h10);
    wb(5'd6, 32'hFFFF_FFFF); issue(it(ADDI, 5, 8, 16'hFFFF), 20'h008); adv(); clr();
    chk("addi_imm", id_ex_imm_out, 32'hFFFF_FFFF);
    chk("addi_rd", 32'(id_ex_rd_out), 32'd8);

    // load-use on rs1, then load moves to MEM and the ADD issues
    ex_mem_read_in = 1; ex_reg_write_in = 1; ex_rd_in = 3;
    issue(rt(3, 2, 4, 11'h20), 20'h00C);
    chk("t2_stall", 32'(stall_out), 32'h1);
    adv(); clr();
    chk("t2_bubble_rw", 32'(id_ex_reg_write_out), 32'h0);
    mem_reg_write_in = 1; mem_rd_in = 3;
    issue(rt(3, 2, 4, 11'h20), 20'h00C);
    chk("t2_release", 32'(stall_out), 32'h0);
    adv(); clr();
    chk("t2_add_rd", 32'(id_ex_rd_out), 32'd4);

    // load-use on SW rs2
    ex_mem_read_in = 1; ex_rd_in = 9;
    issue(it(SW, 2, 9, 16'h4), 20'h010); adv(); clr();
    issue(it(SW, 2, 9, 16'h4), 20'h010); adv();
    chk("sw_mem_write", 32'(id_ex_mem_write_out), 32'h1);

    // J ignores a load whose rd aliases the offset bits
    ex_mem_read_in = 1; ex_rd_in = 5;
    issue(jt(J, 26'h0A0_0004), 20'h014);
    chk("j_nostall", 32'(stall_out), 32'h0);
    chk("j_target", 32'(new_pc_out), 32'h0001C);
    adv(); clr();
    issue(rt(5, 2, 4, 11'h20), 20'h018); adv();

    // BEQZ r0 taken, wrong-path squashed
    issue(it(BEQZ, 0, 0, 16'h8), 20'h100);
    chk("t3_sel", 32'(select_new_pc_out), 32'h1);
    chk("t3_target", 32'(new_pc_out), 32'h10C);
    adv();
    issue(rt(5, 2, 4, 11'h20), 20'h104); adv();
    chk("t3_squash_rw", 32'(id_ex_reg_write_out), 32'h0);
    issue(it(BNEZ, 5, 0, 16'hFFF8), 20'h000);
    chk("bnez_wrap", 32'(new_pc_out), 32'hFFFFC);
    adv(); issue(32'h0, 20'h004); adv();
    issue(it(BEQZ, 5, 0, 16'h40), 20'h020);
    chk("beqz_not_taken", 32'(select_new_pc_out), 32'h0);
    adv();

    // JAL / JR / JALR
    issue(jt(JAL, 26'h40), 20'h200);
    chk("t4_target", 32'(new_pc_out), 32'h244);
    adv();
    chk("t4_rd", 32'(id_ex_rd_out), 32'd31);
    chk("t4_rw", 32'(id_ex_reg_write_out), 32'h1);
    chk("t4_pc4", 32'(id_ex_pc4_out), 32'h204);
    issue(32'h0, 20'h204); adv();
    issue(it(JR, 5, 0, 16'h0), 20'h300);
    chk("jr_target", 32'(new_pc_out), 32'h01234);
    adv(); issue(32'h0, 20'h304); adv();
    issue(it(JALR, 6, 0, 16'h0), 20'h310);
    chk("jalr_target", 32'(new_pc_out), 32'hFFFFF);
    adv(); issue(32'h0, 20'h314); adv();

    // BNEZ operand in EX then MEM, then resolved with WB bypass
    ex_reg_write_in = 1; ex_rd_in = 7;
    issue(it(BNEZ, 7, 0, 16'h10), 20'h400);
    chk("t5_stall_ex", 32'(stall_out), 32'h1);
    chk("t5_no_redirect", 32'(select_new_pc_out), 32'h0);
    adv(); clr();
    mem_reg_write_in = 1; mem_rd_in = 7;
    issue(it(BNEZ, 7, 0, 16'h10), 20'h400);
    chk("t5_stall_mem", 32'(stall_out), 32'h1);
    adv(); clr();
    wb(5'd7, 32'h5);
    issue(it(BNEZ, 7, 0, 16'h10), 20'h400);
    chk("t5_target", 32'(new_pc_out), 32'h414);
    adv(); clr();
    issue(32'h0, 20'h404); adv();

    // r0 ignores writes; reset during flush
    wb(5'd0, 32'hFFFF); issue(rt(0, 0, 1, 11'h0), 20'h500); adv(); clr();
    chk("t6_r0_bypass", id_ex_rs1_data_out, 32'h0);
    issue(rt(0, 0, 1, 11'h0), 20'h504); adv();
    chk("t6_r0_read", id_ex_rs2_data_out, 32'h0);
    issue(it(BEQZ, 0, 0, 16'h8), 20'h600); adv();
    instruction_in = 32'h0; rst_n = 0; do_reset();
    #1;
    chk("t6_rst_pc4", 32'(id_ex_pc4_out), 32'h0);
    chk("t6_rst_rd", 32'(id_ex_rd_out), 32'h0);
    chk("t6_rst_sel", 32'(select_new_pc_out), 32'h0);
    issue(32'h0, 20'h0); adv();
    rst_n = 1;
    issue(it(ADDI, 0, 9, 16'h5), 20'h300);
    chk("t6_post_sel", 32'(select_new_pc_out), 32'h0);
    adv();
    chk("t6_post_rd", 32'(id_ex_rd_out), 32'd9);
    chk("t6_post_rw", 32'(id_ex_reg_write_out), 32'h1);
    chk("t6_post_pc4", 32'(id_ex_pc4_out), 32'h304);
    issue(32'h0, 20'h304); adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
